// File: rtl/color_space_pkg.sv
// Shared colour-space constants for the BT.601 studio-range converters.
// Coefficients are round(real * 2^MSIZE_DEF); both the forward and the
// inverse converter import this package.
package color_space_pkg;

  // Default fractional width of the fixed-point coefficients.
  localparam int MSIZE_DEF = 12;

  // YCbCr -> RGB coefficients at MSIZE_DEF fractional bits.
  localparam int KY  = 4768;  // 1.164
  localparam int KRV = 6537;  // 1.596
  localparam int KGU = 1606;  // 0.392
  localparam int KGV = 3330;  // 0.813
  localparam int KBU = 8262;  // 2.017

  // Studio-range luma black level: 16 at 8 bits, scaled with component width.
  function automatic int luma_off(input int dsize);
    return 1 << (dsize - 4);
  endfunction

  // Chroma zero point: mid-scale of the component range.
  function automatic int chroma_off(input int dsize);
    return 1 << (dsize - 1);
  endfunction

endpackage

// File: rtl/csc_sat_round.sv
// Output stage helper: optional round-half-up, arithmetic shift by MSIZE,
// then clamp into the unsigned DSIZE-bit range. Purely combinational; the
// caller registers the result.
// Build option: define COLOR_SPACE_INV_ROUND_EN to add 2^(MSIZE-1) before
// the shift; otherwise the shift truncates toward minus infinity.
module csc_sat_round
  #(
    parameter int DSIZE = 10,
    parameter int MSIZE = 12,
    parameter int IW    = 25
  )
  (
    input  logic signed [IW-1:0]    sum_i,
    output logic        [DSIZE-1:0] pix_o
  );

  localparam logic signed [IW-1:0] MAX_S = IW'((1 << DSIZE) - 1);

  logic signed [IW-1:0] biased;
  logic signed [IW-1:0] scaled;

`ifdef COLOR_SPACE_INV_ROUND_EN
  localparam logic signed [IW-1:0] HALF_S = IW'(1 << (MSIZE - 1));
  assign biased = sum_i + HALF_S;
`else
  assign biased = sum_i;
`endif

  assign scaled = biased >>> MSIZE;

  // Clamp negative results to black and overshoots to full scale.
  always_comb begin
    pix_o = '0;
    if (scaled[IW-1]) begin
      pix_o = '0;
    end else if (scaled > MAX_S) begin
      pix_o = '1;
    end else begin
      pix_o = scaled[DSIZE-1:0];
    end
  end

endmodule

// File: rtl/color_space_inv.sv
// Pipelined BT.601 studio-range YCbCr -> RGB converter, fixed 4-cycle latency.
// Build option: COLOR_SPACE_INV_ROUND_EN selects round-half-up in the output
// stage (see csc_sat_round); latency, clamping and oen are unaffected.
//
// Pixel qualifier: ien marks a valid input pixel on the clock edge where it
// is sampled; oen is ien delayed by exactly 4 clocks and marks the matching
// output pixel. There is no ready/back-pressure: one pixel may arrive every
// clock and the consumer must take every pixel flagged by oen. Data
// registers advance every clock; outputs are only meaningful when oen=1.
module color_space_inv
  import color_space_pkg::*;
  #(
    parameter int DSIZE = 10,
    parameter int MSIZE = MSIZE_DEF
  )
  (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] inY,
    input  logic [DSIZE-1:0] inCb,
    input  logic [DSIZE-1:0] inCr,
    input  logic             ien,
    output logic [DSIZE-1:0] outR,
    output logic [DSIZE-1:0] outG,
    output logic [DSIZE-1:0] outB,
    output logic             oen
  );

  // Difference width (one sign bit over the component) and product/sum width.
  localparam int DW = DSIZE + 1;
  localparam int PW = DSIZE + MSIZE + 3;

  localparam logic signed [DW-1:0] LUMA_OFF_S   = DW'(luma_off(DSIZE));
  localparam logic signed [DW-1:0] CHROMA_OFF_S = DW'(chroma_off(DSIZE));

  localparam logic signed [PW-1:0] KY_S  = PW'(KY);
  localparam logic signed [PW-1:0] KRV_S = PW'(KRV);
  localparam logic signed [PW-1:0] KGU_S = PW'(KGU);
  localparam logic signed [PW-1:0] KGV_S = PW'(KGV);
  localparam logic signed [PW-1:0] KBU_S = PW'(KBU);

  // Stage 1: offset-removed components
  logic signed [DW-1:0] dy_d,  dy_q;
  logic signed [DW-1:0] dcb_d, dcb_q;
  logic signed [DW-1:0] dcr_d, dcr_q;

  // Stage 2: coefficient products
  logic signed [PW-1:0] dy_ext, dcb_ext, dcr_ext;
  logic signed [PW-1:0] p_ky_d,  p_ky_q;
  logic signed [PW-1:0] p_krv_d, p_krv_q;
  logic signed [PW-1:0] p_kgu_d, p_kgu_q;
  logic signed [PW-1:0] p_kgv_d, p_kgv_q;
  logic signed [PW-1:0] p_kbu_d, p_kbu_q;

  // Stage 3: per-channel sums
  logic signed [PW-1:0] s_r_d, s_r_q;
  logic signed [PW-1:0] s_g_d, s_g_q;
  logic signed [PW-1:0] s_b_d, s_b_q;

  // Stage 4: scaled and clamped outputs
  logic [DSIZE-1:0] r_d, r_q;
  logic [DSIZE-1:0] g_d, g_q;
  logic [DSIZE-1:0] b_d, b_q;

  // Valid shift register, bit 3 is the output qualifier
  logic [3:0] en_d, en_q;

  // Stage 1: subtract studio-range offsets from zero-extended inputs.
  always_comb begin
    dy_d  = $signed({1'b0, inY})  - LUMA_OFF_S;
    dcb_d = $signed({1'b0, inCb}) - CHROMA_OFF_S;
    dcr_d = $signed({1'b0, inCr}) - CHROMA_OFF_S;
  end

  // Stage 2: sign-extend differences to product width and multiply.
  always_comb begin
    dy_ext  = {{(PW-DW){dy_q[DW-1]}},  dy_q};
    dcb_ext = {{(PW-DW){dcb_q[DW-1]}}, dcb_q};
    dcr_ext = {{(PW-DW){dcr_q[DW-1]}}, dcr_q};
    p_ky_d  = KY_S  * dy_ext;
    p_krv_d = KRV_S * dcr_ext;
    p_kgu_d = KGU_S * dcb_ext;
    p_kgv_d = KGV_S * dcr_ext;
    p_kbu_d = KBU_S * dcb_ext;
  end

  // Stage 3: combine products; PW leaves headroom so no sum can overflow.
  always_comb begin
    s_r_d = p_ky_q + p_krv_q;
    s_g_d = p_ky_q - p_kgu_q - p_kgv_q;
    s_b_d = p_ky_q + p_kbu_q;
  end

  // Stage 4: one scale/clamp unit per channel.
  csc_sat_round #(.DSIZE(DSIZE), .MSIZE(MSIZE), .IW(PW)) u_sat_r (
    .sum_i (s_r_q),
    .pix_o (r_d)
  );

  csc_sat_round #(.DSIZE(DSIZE), .MSIZE(MSIZE), .IW(PW)) u_sat_g (
    .sum_i (s_g_q),
    .pix_o (g_d)
  );

  csc_sat_round #(.DSIZE(DSIZE), .MSIZE(MSIZE), .IW(PW)) u_sat_b (
    .sum_i (s_b_q),
    .pix_o (b_d)
  );

  // Valid qualifier travels alongside the data, one bit per stage.
  always_comb begin
    en_d = {en_q[2:0], ien};
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      dy_q    <= '0;
      dcb_q   <= '0;
      dcr_q   <= '0;
      p_ky_q  <= '0;
      p_krv_q <= '0;
      p_kgu_q <= '0;
      p_kgv_q <= '0;
      p_kbu_q <= '0;
      s_r_q   <= '0;
      s_g_q   <= '0;
      s_b_q   <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      en_q    <= '0;
    end else begin
      dy_q    <= dy_d;
      dcb_q   <= dcb_d;
      dcr_q   <= dcr_d;
      p_ky_q  <= p_ky_d;
      p_krv_q <= p_krv_d;
      p_kgu_q <= p_kgu_d;
      p_kgv_q <= p_kgv_d;
      p_kbu_q <= p_kbu_d;
      s_r_q   <= s_r_d;
      s_g_q   <= s_g_d;
      s_b_q   <= s_b_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      en_q    <= en_d;
    end
  end

  assign outR = r_q;
  assign outG = g_q;
  assign outB = b_q;
  assign oen  = en_q[3];

endmodule
